key_dispatcher: RTL

Consumer stage for the LFSR key counter in the RC4 brute-force path. Pulls candidate key values from the counter via its `available`/`counter_read` handshake and zero-extends each to a full key. Hands each key to the lowest-indexed idle RC4 decrypt core. Collects per-core results and reports either the first successful key or exhaustion of the key space.

---
 rtl/rc4_breaker_pkg.sv | 35 +++
 rtl/dispatcher_free_select.sv | 52 +++++
 rtl/key_dispatcher.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rc4_breaker_pkg.sv
// -----------------------------------------------------------------------------
// rc4_breaker_pkg
//   Shared types and constants for the RC4 brute-force key path.
//   - disp_state_e     : key_dispatcher state encoding
//   - KEY_WIDTH_DEFAULT: default width of a candidate key
//   - CNT_WIDTH_*      : supported widths of the LFSR key counter
//   - cnt_width_legal(): true for a supported counter width
//   - idx_width()      : index width for a vector of n entries (min 1)
// -----------------------------------------------------------------------------
package rc4_breaker_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      ASSIGN    = 3'd2,
      DRAIN     = 3'd3,
      FOUND     = 3'd4,
      EXHAUSTED = 3'd5
   } disp_state_e;

   localparam int KEY_WIDTH_DEFAULT = 24;

   localparam int CNT_WIDTH_SMALL = 4;
   localparam int CNT_WIDTH_MID   = 22;
   localparam int CNT_WIDTH_FULL  = 24;

   function automatic logic cnt_width_legal(input int w);
      return (w == CNT_WIDTH_SMALL) || (w == CNT_WIDTH_MID) || (w == CNT_WIDTH_FULL);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dispatcher_free_select.sv
// -----------------------------------------------------------------------------
// dispatcher_free_select
//   Two independent lowest-index priority encoders used by key_dispatcher.
//   Purely combinational.
//   Ports:
//     busy       in  NUM_CORES : core busy flags; a 0 bit marks a free core
//     hit        in  NUM_CORES : cores reporting a successful key this cycle
//     free_idx   out IDX_W     : lowest-indexed free core
//     free_valid out 1         : at least one core is free
//     hit_idx    out IDX_W     : lowest-indexed successful core
//     hit_valid  out 1         : at least one core succeeded
// -----------------------------------------------------------------------------
module dispatcher_free_select
   import rc4_breaker_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = idx_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] busy,
   input  logic [NUM_CORES-1:0] hit,
   output logic [IDX_W-1:0]     free_idx,
   output logic                 free_valid,
   output logic [IDX_W-1:0]     hit_idx,
   output logic                 hit_valid
);

   // NOTE: every output of an always_comb gets a default before any branch;
   // a path that leaves a variable unassigned would infer a latch.
   always_comb begin
      free_idx   = '0;
      free_valid = 1'b0;
      // Scanning downward lets the lowest free index be the last one written.
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx   = IDX_W'(i);
            free_valid = 1'b1;
         end
      end
   end

   always_comb begin
      hit_idx   = '0;
      hit_valid = 1'b0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_idx   = IDX_W'(i);
            hit_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_dispatcher.sv
// -----------------------------------------------------------------------------
// key_dispatcher
//   Pulls candidate keys from the LFSR key counter, zero-extends them and hands
//   each one to the lowest-indexed idle RC4 decrypt core. Collects per-core
//   results and reports the first successful key or exhaustion of the space.
//
//   Optional feature macro: KEY_DISPATCH_STATS_EN
//     defined     -> keys_tried counts core_start pulses, saturating
//     not defined -> keys_tried is tied to 0
//
//   Ports:
//     clk              in  1          : clock
//     reset            in  1          : asynchronous, active-high
//     start            in  1          : dispatching runs while high
//     counter          in  CNT_WIDTH  : candidate value from the counter
//     available        in  1          : counter value valid and unread
//     counter_finished in  1          : key space exhausted
//     counter_read     out 1          : one-cycle read pulse to the counter
//     core_key         out KEY_WIDTH  : key broadcast to all cores
//     core_start       out NUM_CORES  : one-hot start pulse
//     core_done        in  NUM_CORES  : per-core completion pulse
//     core_success     in  NUM_CORES  : qualified by core_done
//     core_stop        out 1          : cores abandon work
//     found            out 1          : sticky, a key succeeded
//     found_key        out KEY_WIDTH  : the successful key
//     exhausted        out 1          : sticky, no key succeeded
//     keys_tried       out 32         : keys dispatched
// -----------------------------------------------------------------------------
module key_dispatcher
   import rc4_breaker_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_FULL,
   parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT,
   parameter int NUM_CORES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] counter,
   input  logic                 available,
   input  logic                 counter_finished,
   output logic                 counter_read,
   output logic [KEY_WIDTH-1:0] core_key,
   output logic [NUM_CORES-1:0] core_start,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_success,
   output logic                 core_stop,
   output logic                 found,
   output logic [KEY_WIDTH-1:0] found_key,
   output logic                 exhausted,
   output logic [31:0]          keys_tried
);

   localparam int IDX_W = idx_width(NUM_CORES);

   disp_state_e          state_q, state_d;
   logic [NUM_CORES-1:0] busy_q, busy_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [KEY_WIDTH-1:0] key_table_q [NUM_CORES];
   logic [KEY_WIDTH-1:0] key_table_d [NUM_CORES];
   logic                 found_q, found_d;
   logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
   logic                 exhausted_q, exhausted_d;

   logic [NUM_CORES-1:0] hit_vec;
   logic [NUM_CORES-1:0] start_vec;
   logic [IDX_W-1:0]     free_idx, hit_idx;
   logic                 free_valid, hit_valid;
   logic                 collect;

   // Only cores that were actually handed a key can report one; this keeps a
   // result still in flight across a reset from being accepted afterwards.
   assign hit_vec = core_done & core_success & busy_q;

   // Results are gathered in every non-terminal state, including IDLE, so a
   // run paused by dropping start still reports work already handed out.
   assign collect = (state_q == IDLE) || (state_q == FETCH) ||
                    (state_q == ASSIGN) || (state_q == DRAIN);

   dispatcher_free_select #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_free_select (
      .busy       (busy_q),
      .hit        (hit_vec),
      .free_idx   (free_idx),
      .free_valid (free_valid),
      .hit_idx    (hit_idx),
      .hit_valid  (hit_valid)
   );

   always_comb begin
      state_d      = state_q;
      // A core_done in this cycle frees the core only from the next cycle,
      // because selection below uses the registered busy_q.
      busy_d       = busy_q & ~core_done;
      key_d        = key_q;
      key_table_d  = key_table_q;
      found_d      = found_q;
      found_key_d  = found_key_q;
      exhausted_d  = exhausted_q;
      counter_read = 1'b0;
      start_vec    = '0;

      if (collect && hit_valid) begin
         // Success pre-empts everything: no read, no start, pending key dropped.
         state_d     = FOUND;
         found_d     = 1'b1;
         found_key_d = key_table_q[hit_idx];
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) state_d = FETCH;
            end
            FETCH: begin
               if (!start) begin
                  state_d = IDLE;
               end else if (counter_finished) begin
                  state_d = DRAIN;
               end else if (available && free_valid) begin
                  counter_read           = 1'b1;
                  key_d                  = '0;
                  key_d[CNT_WIDTH-1:0]   = counter;
                  state_d                = ASSIGN;
               end
            end
            ASSIGN: begin
               // A core free in FETCH stays free here, so free_valid holds.
               if (free_valid) begin
                  start_vec[free_idx]   = 1'b1;
                  busy_d[free_idx]      = 1'b1;
                  key_table_d[free_idx] = key_q;
               end
               state_d = FETCH;
            end
            DRAIN: begin
               if (busy_q == '0) begin
                  state_d     = EXHAUSTED;
                  exhausted_d = 1'b1;
               end
            end
            FOUND, EXHAUSTED: begin
               state_d = state_q;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= '0;
         key_q       <= '0;
         found_q     <= 1'b0;
         found_key_q <= '0;
         exhausted_q <= 1'b0;
         // NOTE: the key table is small and read straight into found_key, so it
         // is reset to keep a stale key from ever being reported.
         for (int i = 0; i < NUM_CORES; i++) begin
            key_table_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         key_q       <= key_d;
         found_q     <= found_d;
         found_key_q <= found_key_d;
         exhausted_q <= exhausted_d;
         key_table_q <= key_table_d;
      end
   end

   assign core_start = start_vec;
   assign core_key   = key_q;
   assign core_stop  = (state_q == FOUND) || (state_q == EXHAUSTED);
   assign found      = found_q;
   assign found_key  = found_key_q;
   assign exhausted  = exhausted_q;

`ifdef KEY_DISPATCH_STATS_EN
   logic [31:0] keys_tried_q, keys_tried_d;

   always_comb begin
      keys_tried_d = keys_tried_q;
      if ((|start_vec) && (keys_tried_q != 32'hFFFF_FFFF)) begin
         keys_tried_d = keys_tried_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keys_tried_q <= '0;
      end else begin
         keys_tried_q <= keys_tried_d;
      end
   end

   assign keys_tried = keys_tried_q;
`else
   assign keys_tried = 32'd0;
`endif

endmodule
